dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single data-memory port.
// A request is taken in IDLE, the winner's fields are latched, the memory
// is strobed for one ACCESS cycle, and reads then wait RD_LATENCY cycles
// before the returned word is presented for one RESP cycle.
//
// Handshake: a requester raises req<n> with we/op/addr/wdata and holds all
// of them stable until it sees gnt<n> (one cycle, first ACCESS cycle). The
// grant is the acknowledge; req<n> still high after gnt<n> is a new request.
// Requests are only sampled in IDLE. Read data is qualified by the one-cycle
// rvalid<n> strobe; rdata<n> then holds until that port's next read returns.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prio_fixed,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [2:0]            op0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [2:0]            op1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [2:0]            mem_op,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    // owner_q is both the port being served and the last-granted pointer
    logic               owner_q;
    logic               lat_we_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               any_req;
    logic               win;
    logic               last_wait;

    assign last_wait = (cnt_q <= CNT_W'(1));

    // Arbitration and next-state selection
    always_comb begin
        state_d = state_q;
        any_req = req0 | req1;
        win     = 1'b0;
        if (req0 && req1) begin
            // Tie: fixed mode favours port 0, round-robin favours the port
            // that did not win last time.
            win = prio_fixed ? 1'b0 : ~owner_q;
        end else begin
            win = ~req0;
        end
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = lat_we_q ? IDLE : WAIT;
            WAIT:    if (last_wait) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's request fields and record it as last granted
    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q  <= 1'b1;
            lat_we_q <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_op   <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q  <= win;
            lat_we_q <= win ? we1 : we0;
            mem_addr <= win ? addr1 : addr0;
            mem_din  <= win ? wdata1 : wdata0;
            mem_op   <= win ? op1 : op0;
        end
    end

    // Read latency down-counter: loaded on a read ACCESS, runs in WAIT
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !lat_we_q) begin
            cnt_q <= CNT_W'(RD_LATENCY);
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Capture returned memory data for the owning port on the last WAIT cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state_q == WAIT && last_wait) begin
            if (owner_q) begin
                rdata1 <= mem_dout;
            end else begin
                rdata0 <= mem_dout;
            end
        end
    end

    assign gnt0      = (state_q == ACCESS) && !owner_q;
    assign gnt1      = (state_q == ACCESS) &&  owner_q;
    assign mem_we    = (state_q == ACCESS) &&  lat_we_q;
    assign mem_re    = (state_q == ACCESS) && !lat_we_q;
    assign rvalid0   = (state_q == RESP)   && !owner_q;
    assign rvalid1   = (state_q == RESP)   &&  owner_q;
    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule
